// File: rtl/amiga_clk_pkg.sv
// Shared constants and phase names for the Minimig clock-enable generator.
// cnt phase | meaning
// PH_C0     | first 28 MHz slot after the 7 MHz edge
// PH_C1     | clk7n_en slot
// PH_C2     | c3 rises
// PH_C3     | clk7_en slot, cck/ecnt advance
package amiga_clk_pkg;
    localparam int CNT7_W = 2;
    localparam int ECNT_W = 4;
    localparam int ECLK_N = 10;
    localparam logic [ECNT_W-1:0] ECNT_MAX     = 4'd9;
    localparam logic [ECNT_W-1:0] E_HIGH_FIRST = 4'd6;

    typedef enum logic [CNT7_W-1:0] {
        PH_C0 = 2'd0,
        PH_C1 = 2'd1,
        PH_C2 = 2'd2,
        PH_C3 = 2'd3
    } ph_e;
endpackage

// File: rtl/amiga_clk_en_gen_sync_ff.sv
// N-stage single-bit synchroniser with synchronous clear.
module sync_ff #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);
    logic [N-1:0] sr;

    always_ff @(posedge clk) begin
        if (clr) sr <= '0;
        else     sr <= {sr[N-2:0], d};
    end

    assign q = sr[N-1];
endmodule

// File: rtl/amiga_clk_en_gen.sv
// 28 MHz timing-enable generator: 7 MHz enables, c1/c3, cck, E-clock and
// the lock-qualified system reset, all from one shared phase counter.
module amiga_clk_en_gen
    import amiga_clk_pkg::*;
#(
    parameter int LOCK_DELAY  = 1024,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pll_locked,
    output logic              locked_sync,
    output logic              sys_rst,
    output logic              clk7_en,
    output logic              clk7n_en,
    output logic              c1,
    output logic              c3,
    output logic              cck,
    output logic [ECLK_N-1:0] eclk,
    output logic              e_clk
);
    localparam int LOCK_W = $clog2(LOCK_DELAY + 1);
    localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_DELAY);

    logic              hold;
    logic              at_c3;
    logic [CNT7_W-1:0] cnt;
    logic [ECNT_W-1:0] ecnt;
    logic [LOCK_W-1:0] lock_cnt;
    logic              cck_q;
    logic              sys_rst_q;

    sync_ff #(.N(SYNC_STAGES)) u_lock_sync (
        .clk (clk),
        .clr (rst),
        .d   (pll_locked),
        .q   (locked_sync)
    );

    assign hold  = rst | ~locked_sync;
    assign at_c3 = (cnt == PH_C3);

    // Release only on a PH_C3 edge so the first unreset cycle starts at PH_C0.
    always_ff @(posedge clk) begin
        if (hold) begin
            cnt       <= '0;
            ecnt      <= '0;
            cck_q     <= 1'b0;
            lock_cnt  <= '0;
            sys_rst_q <= 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
            if (lock_cnt != LOCK_MAX) lock_cnt <= lock_cnt + 1'b1;
            if (at_c3) begin
                cck_q <= ~cck_q;
                ecnt  <= (ecnt == ECNT_MAX) ? '0 : ecnt + 1'b1;
                if (lock_cnt == LOCK_MAX) sys_rst_q <= 1'b0;
            end
        end
    end

    assign sys_rst  = sys_rst_q;
    assign clk7_en  = at_c3;
    assign clk7n_en = (cnt == PH_C1);
    assign c1       = cnt[1] ^ cnt[0];
    assign c3       = cnt[1];
    assign cck      = cck_q;
    assign e_clk    = (ecnt >= E_HIGH_FIRST);

    always_comb begin
        eclk = '0;
        for (int i = 0; i < ECLK_N; i++) eclk[i] = (ecnt == ECNT_W'(i));
    end
endmodule

// File: tb/tb_amiga_clk_en_gen.sv
// Bench for amiga_clk_en_gen: directed phases plus random lock/reset traffic,
// checked every cycle against a "cycles since hold dropped" reference model.
module tb_amiga_clk_en_gen;
    localparam int LD  = 8;
    localparam int SS  = 2;
    localparam int REL = ((LD + 4) / 4) * 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       locked_sync, sys_rst, clk7_en, clk7n_en, c1, c3, cck, e_clk;
    logic [9:0] eclk;

    int checks = 0;
    int errors = 0;

    // reference model state
    int            run;
    logic [SS-1:0] sq;

    amiga_clk_en_gen #(.LOCK_DELAY(LD), .SYNC_STAGES(SS)) dut (
        .clk         (clk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .locked_sync (locked_sync),
        .sys_rst     (sys_rst),
        .clk7_en     (clk7_en),
        .clk7n_en    (clk7n_en),
        .c1          (c1),
        .c3          (c3),
        .cck         (cck),
        .eclk        (eclk),
        .e_clk       (e_clk)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic lk);
        int ph, ec;
        bit hold_m;
        rst        = r;
        pll_locked = lk;
        @(posedge clk);
        hold_m = r || !sq[SS-1];
        run    = hold_m ? 0 : run + 1;
        sq     = r ? '0 : {sq, lk};
        #1;
        ph = run % 4;
        ec = (run / 4) % 10;
        check("locked_sync", locked_sync, sq[SS-1]);
        check("sys_rst",     sys_rst,     run < REL);
        check("clk7_en",     clk7_en,     ph == 3);
        check("clk7n_en",    clk7n_en,    ph == 1);
        check("c1",          c1,          ph == 1 || ph == 2);
        check("c3",          c3,          ph >= 2);
        check("cck",         cck,         (run / 4) % 2);
        check("eclk",        eclk,        32'd1 << ec);
        check("e_clk",       e_clk,       ec >= 6);
    endtask

    initial begin
        int  n;
        bit  lk;
        run = 0;
        sq  = '0;

        // reset held with the PLL already reporting lock
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1);

        // first lock: release latency counted from the first unreset edge
        n = 0;
        while (sys_rst !== 1'b0 && n < 60) begin
            step(1'b0, 1'b1);
            n++;
        end
        check("release_latency", n, SS + REL);
        check("release_c3", c3, 1'b0);

        for (int i = 0; i < 80; i++) step(1'b0, 1'b1);

        // lose lock while ecnt == 7
        n = 0;
        while (eclk !== 10'h080 && n < 100) begin
            step(1'b0, 1'b1);
            n++;
        end
        check("ecnt7_reached", eclk, 10'h080);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("drop_locked_sync", locked_sync, 1'b0);
        step(1'b0, 1'b0);
        check("drop_sys_rst", sys_rst, 1'b1);
        check("drop_eclk", eclk, 10'h001);
        check("drop_clk7_en", clk7_en, 1'b0);

        // relock, glitch partway through the wait, then full wait again
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
        check("wait_sys_rst", sys_rst, 1'b1);
        step(1'b0, 1'b0);
        n = 0;
        while (sys_rst !== 1'b0 && n < 60) begin
            step(1'b0, 1'b1);
            n++;
        end
        check("relock_latency", n, SS + REL);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1);

        // one-cycle rst on a PH_C3 edge
        n = 0;
        while (clk7_en !== 1'b1 && n < 8) begin
            step(1'b0, 1'b1);
            n++;
        end
        check("rst_at_c3", clk7_en, 1'b1);
        step(1'b1, 1'b1);
        check("rst_pulse_cck", cck, 1'b0);
        check("rst_pulse_sys_rst", sys_rst, 1'b1);
        n = 0;
        while (sys_rst !== 1'b0 && n < 60) begin
            step(1'b0, 1'b1);
            n++;
        end
        check("post_rst_latency", n, SS + REL);

        // random lock drops and reset pulses
        lk = 1'b1;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 29) == 0) lk = ~lk;
            step($urandom_range(0, 99) == 0, lk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
